// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forwarding selects, hazard FSM states and
// the bundle of stall/flush strobes driven into the pipeline registers.
package cpu_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_INJECT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_IDLE = 6'b000000;

    // A memory freeze holds every stage and never flushes anything.
    function automatic pipe_ctl_t ctl_freeze();
        pipe_ctl_t c;
        c              = CTL_IDLE;
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select. The younger producer (EX_MEM) wins
// over MEM_WB; register 0 is an ordinary register here.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int RAW = 4
) (
    input  logic [RAW-1:0] ex_rs1,
    input  logic [RAW-1:0] ex_rs2,
    input  logic [RAW-1:0] mem_reg_dst,
    input  logic           mem_reg_wr,
    input  logic [RAW-1:0] wb_reg_dst,
    input  logic           wb_reg_wr,
    output fwd_sel_t       fwd_a,
    output fwd_sel_t       fwd_b
);

    function automatic fwd_sel_t pick(
        input logic [RAW-1:0] rs,
        input logic           m_wr,
        input logic [RAW-1:0] m_dst,
        input logic           w_wr,
        input logic [RAW-1:0] w_dst
    );
        fwd_sel_t sel;
        if (m_wr && (m_dst == rs)) begin
            sel = FWD_MEM;
        end else if (w_wr && (w_dst == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Select source for both EX operands.
    always_comb begin
        fwd_a = pick(ex_rs1, mem_reg_wr, mem_reg_dst, wb_reg_wr, wb_reg_dst);
        fwd_b = pick(ex_rs2, mem_reg_wr, mem_reg_dst, wb_reg_wr, wb_reg_dst);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: load-use bubbles, branch flushes, memory
// freeze, interrupt drain/inject sequencing and a saturating stall counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int RAW       = 4,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RAW-1:0]   ex_rs1,
    input  logic [RAW-1:0]   ex_rs2,
    input  logic [RAW-1:0]   ex_reg_dst,
    input  logic             ex_reg_wr,
    input  logic             ex_wb_sel,
    input  logic [RAW-1:0]   mem_reg_dst,
    input  logic             mem_reg_wr,
    input  logic [RAW-1:0]   wb_reg_dst,
    input  logic             wb_reg_wr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             intr_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             intr_inject,
    output logic             intr_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);

    hz_state_t        state_q, state_d;
    logic [DCW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_t  fwd_a_s, fwd_b_s;
    pipe_ctl_t ctl_s;
    logic      lu_s;
    logic      inject_s;

    fwd_unit #(
        .RAW (RAW)
    ) u_fwd (
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .mem_reg_dst (mem_reg_dst),
        .mem_reg_wr  (mem_reg_wr),
        .wb_reg_dst  (wb_reg_dst),
        .wb_reg_wr   (wb_reg_wr),
        .fwd_a       (fwd_a_s),
        .fwd_b       (fwd_b_s)
    );

    // Load in EX whose result the ID instruction needs next cycle.
    always_comb begin
        lu_s = ex_reg_wr && ex_wb_sel &&
               ((id_use1 && (id_rs1 == ex_reg_dst)) ||
                (id_use2 && (id_rs2 == ex_reg_dst)));
    end

    // Stall/flush priority: freeze > interrupt sequencing > branch > load-use.
    always_comb begin
        ctl_s    = CTL_IDLE;
        inject_s = 1'b0;
        if (mem_busy) begin
            ctl_s = ctl_freeze();
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (branch_taken) begin
                        ctl_s.if_id_flush = 1'b1;
                        ctl_s.id_ex_flush = 1'b1;
                    end else if (lu_s) begin
                        ctl_s.pc_stall    = 1'b1;
                        ctl_s.if_id_stall = 1'b1;
                        ctl_s.id_ex_flush = 1'b1;
                    end else begin
                        ctl_s = CTL_IDLE;
                    end
                end
                HZ_DRAIN: begin
                    // IF_ID is being emptied, so load-use cannot arise here.
                    ctl_s.pc_stall    = 1'b1;
                    ctl_s.if_id_flush = 1'b1;
                    ctl_s.id_ex_flush = branch_taken;
                end
                HZ_INJECT: begin
                    ctl_s.pc_stall    = 1'b1;
                    ctl_s.if_id_flush = 1'b1;
                end
                default: begin
                    ctl_s = CTL_IDLE;
                end
            endcase
        end
        // The slot stays offered through a freeze; ID_EX is stalled so it lands once.
        if (state_q == HZ_INJECT) begin
            inject_s = 1'b1;
        end else begin
            inject_s = 1'b0;
        end
    end

    // Interrupt FSM and drain counter next-state; both hold while frozen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (intr_req && !mem_busy && !lu_s) begin
                    state_d = HZ_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            HZ_DRAIN: begin
                if (mem_busy) begin
                    state_d = HZ_DRAIN;
                end else if (cnt_q == {DCW{1'b0}}) begin
                    state_d = HZ_INJECT;
                end else begin
                    cnt_d = cnt_q - DCW'(1);
                end
            end
            HZ_INJECT: begin
                if (mem_busy) begin
                    state_d = HZ_INJECT;
                end else begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = {DCW{1'b0}};
            end
        endcase
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        if (ctl_s.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, drain counter and performance counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HZ_RUN;
            cnt_q       <= {DCW{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Every control output is forced quiet while reset is asserted.
    always_comb begin
        if (rst_n) begin
            pc_stall     = ctl_s.pc_stall;
            if_id_stall  = ctl_s.if_id_stall;
            if_id_flush  = ctl_s.if_id_flush;
            id_ex_stall  = ctl_s.id_ex_stall;
            id_ex_flush  = ctl_s.id_ex_flush;
            ex_mem_stall = ctl_s.ex_mem_stall;
            fwd_a        = fwd_a_s;
            fwd_b        = fwd_b_s;
            intr_inject  = inject_s;
            intr_ack     = inject_s;
        end else begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_stall  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_stall = 1'b0;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
            intr_inject  = 1'b0;
            intr_ack     = 1'b0;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational vectors plus
// hand-written interrupt, freeze, saturation and reset sequences.
module tb_hazard_ctrl;

    localparam int RAW       = 4;
    localparam int DRAIN_CYC = 2;
    localparam int CNT_W     = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_reg_dst, mem_reg_dst, wb_reg_dst;
    logic id_use1, id_use2, ex_reg_wr, ex_wb_sel, mem_reg_wr, wb_reg_wr;
    logic branch_taken, mem_busy, intr_req;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [1:0] fwd_a, fwd_b;
    logic intr_inject, intr_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [11:0] act;

    always #5 clk = ~clk;

    hazard_ctrl #(.RAW(RAW), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_dst(ex_reg_dst),
        .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel),
        .mem_reg_dst(mem_reg_dst), .mem_reg_wr(mem_reg_wr),
        .wb_reg_dst(wb_reg_dst), .wb_reg_wr(wb_reg_wr),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .intr_req(intr_req),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .intr_inject(intr_inject), .intr_ack(intr_ack), .stall_cnt(stall_cnt)
    );

    // {pc_stall,if_id_stall,if_id_flush,id_ex_stall,id_ex_flush,ex_mem_stall,fwd_a,fwd_b,inject,ack}
    assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
                  fwd_a, fwd_b, intr_inject, intr_ack};

    // flags = {id_use1,id_use2,ex_reg_wr,ex_wb_sel,mem_reg_wr,wb_reg_wr,branch_taken,mem_busy}
    typedef struct {
        string      nm;
        logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_dst, mem_dst, wb_dst;
        logic [7:0] flags;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [11:0] v;
    } exp_t;

    vec_t tab[13];
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic quiet();
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rs1 = 4'd0; ex_rs2 = 4'd0;
        ex_reg_dst = 4'd0; mem_reg_dst = 4'd0; wb_reg_dst = 4'd0;
        id_use1 = 1'b0; id_use2 = 1'b0; ex_reg_wr = 1'b0; ex_wb_sel = 1'b0;
        mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; intr_req = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
        ex_reg_dst = v.ex_dst; mem_reg_dst = v.mem_dst; wb_reg_dst = v.wb_dst;
        {id_use1, id_use2, ex_reg_wr, ex_wb_sel, mem_reg_wr, wb_reg_wr, branch_taken, mem_busy} = v.flags;
        intr_req = 1'b0;
    endtask

    task automatic push(input string nm, input logic [11:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %b, nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.nm, act, e.v);
            end
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [CNT_W-1:0] e);
        total++;
        if (stall_cnt !== e) begin
            bad++;
            $display("FAIL %s: stall_cnt got %0d want %0d", nm, stall_cnt, e);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [11:0] e);
        push(nm, e);
        @(negedge clk);
        check_pop();
    endtask

    task automatic do_reset();
        nxt();
        rst_n = 1'b0;
        quiet();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{"fwd_mem",    4'd0, 4'd0, 4'd3, 4'd7, 4'd0, 4'd3, 4'd3, 8'b0000_1100, 12'b000000_01_00_00};
        tab[1]  = '{"fwd_wb",     4'd0, 4'd0, 4'd3, 4'd7, 4'd0, 4'd3, 4'd3, 8'b0000_0100, 12'b000000_10_00_00};
        tab[2]  = '{"fwd_split",  4'd0, 4'd0, 4'd2, 4'd3, 4'd0, 4'd2, 4'd3, 8'b0000_1100, 12'b000000_01_10_00};
        tab[3]  = '{"fwd_r0",     4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 8'b0000_1000, 12'b000000_01_01_00};
        tab[4]  = '{"fwd_nowr",   4'd0, 4'd0, 4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 8'b0000_0000, 12'b000000_00_00_00};
        tab[5]  = '{"lu_rs2",     4'd0, 4'd5, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0111_0000, 12'b110010_00_00_00};
        tab[6]  = '{"lu_nouse",   4'd0, 4'd5, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0011_0000, 12'b000000_00_00_00};
        tab[7]  = '{"lu_noload",  4'd0, 4'd5, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0110_0000, 12'b000000_00_00_00};
        tab[8]  = '{"lu_rs1",     4'd5, 4'd0, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b1011_0000, 12'b110010_00_00_00};
        tab[9]  = '{"lu_branch",  4'd0, 4'd5, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0111_0010, 12'b001010_00_00_00};
        tab[10] = '{"br_only",    4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0000_0010, 12'b001010_00_00_00};
        tab[11] = '{"busy_all",   4'd0, 4'd5, 4'd4, 4'd2, 4'd5, 4'd4, 4'd2, 8'b0111_1111, 12'b110101_01_10_00};
        tab[12] = '{"lu_otherreg",4'd0, 4'd6, 4'd1, 4'd2, 4'd5, 4'd9, 4'd9, 8'b0111_0000, 12'b000000_00_00_00};

        // Reset state: outputs gated off even with provoking inputs.
        rst_n = 1'b0;
        quiet();
        mem_busy   = 1'b1;
        mem_reg_wr = 1'b1;
        #2;
        push("reset_outs", 12'b0);
        check_pop();
        chk_cnt("reset_cnt", 4'd0);

        // Combinational vectors in RUN.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            nxt();
            apply_vec(tab[i]);
            chk(tab[i].nm, tab[i].exp);
        end

        // Interrupt entry: 2 drain cycles, one inject, lu ignored, branch in drain.
        do_reset();
        nxt(); intr_req = 1'b1;
        chk("t4_run", 12'b000000_00_00_00);
        nxt(); ex_reg_wr = 1'b1; ex_wb_sel = 1'b1; ex_reg_dst = 4'd5; id_use1 = 1'b1; id_rs1 = 4'd5;
        chk("t4_drain1_lu", 12'b101000_00_00_00);
        nxt(); ex_reg_wr = 1'b0; ex_wb_sel = 1'b0; id_use1 = 1'b0; branch_taken = 1'b1;
        chk("t4_drain2_br", 12'b101010_00_00_00);
        nxt(); branch_taken = 1'b0;
        chk("t4_inject", 12'b101000_00_00_11);
        nxt(); intr_req = 1'b0;
        chk("t4_back_run", 12'b000000_00_00_00);
        chk_cnt("t4_cnt", 4'd3);

        // Freeze during drain and inject.
        do_reset();
        nxt(); intr_req = 1'b1;
        chk("t5_run", 12'b000000_00_00_00);
        nxt();
        chk("t5_drain1", 12'b101000_00_00_00);
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_busy = 1'b1; mem_reg_wr = 1'b1;
            chk($sformatf("t5_frz%0d", i), 12'b110101_01_01_00);
        end
        nxt(); mem_busy = 1'b0; mem_reg_wr = 1'b0;
        chk("t5_drain2", 12'b101000_00_00_00);
        nxt(); mem_busy = 1'b1;
        chk("t5_inj_frz", 12'b110101_00_00_11);
        nxt(); mem_busy = 1'b0;
        chk("t5_inject", 12'b101000_00_00_11);
        nxt(); intr_req = 1'b0;
        chk("t5_back_run", 12'b000000_00_00_00);
        chk_cnt("t5_cnt", 4'd8);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            nxt(); mem_busy = 1'b1;
            @(negedge clk);
            if (i == 14) chk_cnt("t6_cnt14", 4'd14);
            if (i == 15) chk_cnt("t6_sat", 4'd15);
        end
        for (int i = 0; i < 3; i++) begin
            nxt();
        end
        @(negedge clk);
        chk_cnt("t6_hold", 4'd15);

        // Reset in the middle of a drain.
        nxt(); mem_busy = 1'b0; intr_req = 1'b1;
        chk("t6_run", 12'b000000_00_00_00);
        nxt();
        chk("t6_drain", 12'b101000_00_00_00);
        #1;
        rst_n = 1'b0; mem_busy = 1'b1; mem_reg_wr = 1'b1;
        #1;
        push("t6_rst_outs", 12'b0);
        check_pop();
        chk_cnt("t6_rst_cnt", 4'd0);
        nxt();
        nxt(); rst_n = 1'b1; quiet();
        chk("t6_after_rst", 12'b000000_00_00_00);
        nxt();
        chk("t6_run2", 12'b000000_00_00_00);
        chk_cnt("t6_cnt_after", 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
